// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: MEM stage of an RV32I-style pipeline.
// Byte-organised little-endian data memory with combinational (zero-latency)
// loads, sized stores (SB/SH/SW) that commit on the rising clock edge, a
// saturating committed-store counter and optional misalignment checking.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (defined -> misaligned
// half/word accesses are flagged, such stores are dropped and such loads read
// 0; undefined -> MisalignM/ErrStickyM are tied low and unaligned accesses
// proceed byte-wise with address wrap-around).
// Storage is not cleared by reset; only the counter and the sticky flag are.
module pipeline_mem_stage #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic             MemWriteM,
    input  logic [2:0]       Funct3M,
    output logic [WIDTH-1:0] RDDataMemM,
    output logic             MisalignM,
    output logic             ErrStickyM,
    output logic [15:0]      StoreCountM
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] lane_addr [4];
    logic [7:0]            rd_byte [4];
    logic [31:0]           rd_word;
    logic [31:0]           load_data;
    logic [3:0]            lane_we;
    logic                  misalign;
    logic                  store_commit;
    logic [15:0]           count_reg;
    logic                  sticky_reg;
    // Upper address bits beyond the decoded range are intentionally ignored.
    logic                  unused_bits;

    assign addr        = ALUResultM[ADDR_WIDTH-1:0];
    assign unused_bits = ^ALUResultM;

    // Each byte lane addresses its own byte; the ADDR_WIDTH-bit add wraps
    // naturally, which gives modulo-2**ADDR_WIDTH wrap for multi-byte accesses.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi] = addr + ADDR_WIDTH'(gi);
            assign rd_byte[gi]   = mem[lane_addr[gi]];
        end
    endgenerate

    assign rd_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

`ifdef MEM_MISALIGN_CHECK_EN
    // Funct3M alone decides the access size, so the check applies to the
    // current access whether it is a load or a store.
    always_comb begin
        misalign = 1'b0;
        if ((Funct3M == F3_H || Funct3M == F3_HU) && addr[0])
            misalign = 1'b1;
        else if (Funct3M == F3_W && addr[1:0] != 2'b00)
            misalign = 1'b1;
    end
`else
    assign misalign = 1'b0;
`endif

    // Byte-lane write enables for the store size; unsupported sizes write nothing.
    always_comb begin
        lane_we = 4'b0000;
        case (Funct3M)
            F3_B:    lane_we = 4'b0001;
            F3_H:    lane_we = 4'b0011;
            F3_W:    lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    end

    assign store_commit = MemWriteM && (lane_we != 4'b0000) && !misalign;

    // Load extension; a misaligned (checked) load or a non-load funct3 reads 0.
    always_comb begin
        load_data = 32'h0;
        if (!misalign) begin
            case (Funct3M)
                F3_B:    load_data = {{24{rd_word[7]}}, rd_word[7:0]};
                F3_H:    load_data = {{16{rd_word[15]}}, rd_word[15:0]};
                F3_W:    load_data = rd_word;
                F3_BU:   load_data = {24'h0, rd_word[7:0]};
                F3_HU:   load_data = {16'h0, rd_word[15:0]};
                default: load_data = 32'h0;
            endcase
        end
    end

    assign RDDataMemM = WIDTH'(load_data);

    // Store commit: only enabled lanes are written, so untouched bytes keep
    // their value. The reset branch is deliberately empty: reset blocks the
    // write but never clears the storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (store_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i])
                    mem[lane_addr[i]] <= WriteDataM[8*i +: 8];
            end
        end
    end

    // Committed-store counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_reg <= 16'h0000;
        else if (store_commit && count_reg != 16'hFFFF)
            count_reg <= count_reg + 16'h0001;
    end

    // Sticky misalignment flag: set on any edge that sees a misaligned access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_reg <= 1'b0;
        else if (misalign)
            sticky_reg <= 1'b1;
    end

    assign MisalignM   = misalign;
    assign ErrStickyM  = sticky_reg;
    assign StoreCountM = count_reg;

endmodule

// File: doc/pipeline_mem_stage.md
PIPELINE_MEM_STAGE -- requirements
Module: pipeline_mem_stage

Interface
REQ-001 Parameter WIDTH, default 32, data/address width in bits.
REQ-002 Parameter ADDR_WIDTH, default 17, byte-address bits decoded; storage = 2**ADDR_WIDTH bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ALUResultM  input  WIDTH  byte address from the EX/MEM register.
REQ-006 WriteDataM  input  WIDTH  store data; low bytes used for SB/SH.
REQ-007 MemWriteM  input  1  store request for this cycle.
REQ-008 Funct3M  input  3  access size/sign, RV32I load/store encoding.
REQ-009 RDDataMemM  output  WIDTH  extended load data, feeds the MEM/WB register.
REQ-010 MisalignM  output  1  current access is misaligned (see Configuration).
REQ-011 ErrStickyM  output  1  sticky misalignment flag.
REQ-012 StoreCountM  output  16  count of committed stores.

Function
REQ-013 Storage SHALL be byte-organised little-endian; effective address = ALUResultM[ADDR_WIDTH-1:0]; multi-byte accesses wrap modulo 2**ADDR_WIDTH.
REQ-014 Reads SHALL be combinational from address and Funct3M, with zero-cycle latency.
REQ-015 Load extension SHALL be: 000 LB sign-ext byte; 001 LH sign-ext half; 010 LW word; 100 LBU zero-ext byte; 101 LHU zero-ext half; 011/110/111 give 0.
REQ-016 A store SHALL commit at the rising edge when MemWriteM=1, rst_n=1 and the access is not suppressed.
REQ-017 Store sizes SHALL be: 000 SB writes byte[7:0]; 001 SH writes [15:0]; 010 SW writes [31:0]; other Funct3M values write nothing and are not counted.
REQ-018 Bytes outside the store width SHALL remain unchanged.
REQ-019 A read in the same cycle as a store to the same address SHALL return the pre-store contents; the new data is visible from the next cycle.
REQ-020 StoreCountM SHALL increment by 1 per committed store and saturate at 16'hFFFF.
REQ-021 RDDataMemM SHALL be driven regardless of MemWriteM; the downstream ResultSrc selects its use.

Reset
REQ-022 While rst_n=0: StoreCountM=0, ErrStickyM=0, and no store commits even if MemWriteM=1.
REQ-023 Storage contents SHALL NOT be cleared by reset.
REQ-024 Deassertion of rst_n SHALL take effect at the next rising clk edge; a store presented on that edge commits.

Configuration
REQ-025 Macro MEM_MISALIGN_CHECK_EN selects misalignment checking.
REQ-026 With the macro defined: MisalignM=1 for LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; such stores are suppressed and uncounted; such loads return 0; ErrStickyM sets at the edge where MisalignM=1 and holds until reset.
REQ-027 With the macro undefined: MisalignM and ErrStickyM are tied 0; unaligned accesses proceed byte-wise per REQ-013.

Verification
REQ-028 SW 0x8000_00FF to 0x100, then LB/LBU/LH/LW at 0x100 -> 0xFFFFFFFF, 0x000000FF, 0x000000FF, 0x800000FF.
REQ-029 SW 0x11223344 to 0x200, then SB 0xAA to 0x201 -> LW 0x200 = 0x1122AA44; StoreCountM = 2.
REQ-030 Store and load to 0x300 in the same cycle (old 0, new 0x5A5A5A5A) -> RDDataMemM=0 that cycle, 0x5A5A5A5A the next.
REQ-031 With MEM_MISALIGN_CHECK_EN: SW 0xDEADBEEF to 0x402 -> MisalignM=1, memory unchanged, StoreCountM unchanged, ErrStickyM=1 from the next cycle until rst_n low.
REQ-032 rst_n pulsed low mid-stream with MemWriteM=1 -> no write, StoreCountM=0 immediately (asynchronous), earlier data at 0x200 still reads 0x1122AA44.
REQ-033 Force StoreCountM to 0xFFFE, issue 3 stores -> count reaches 0xFFFF and holds.
